sfft_frame_readout: RTL and testbench
=====================================

# sfft_frame_readout

Parametrised, double-buffered readout stage between the SFFT pipeline and the 8-bit memory-mapped driver port. Captures one complete frame of `NFFT` bins per SFFT output pass into a write bank and publishes it atomically by swapping banks. Also maintains a frame timestamp and sticky overrun/framing status. Software reads bins byte-wise and holds a lock bit so the bank under read is never overwritten.

## Interface
Parameters:
- `NFFT`, 512 — bins per frame; power of 2, ≥ 4.
- `WORD_W`, 32 — bits per bin; multiple of 8, ≤ 64. `BYTES = WORD_W/8`.
- `TIME_W`, 32 — frame counter width; multiple of 8, ≤ 32.
- `ADDR_W`, 16 — byte address width; requires `NFFT*BYTES + 8 ≤ 2**ADDR_W`.

Ports:
- `clk` in 1 — single clock.
- `reset` in 1 — asynchronous, active-low.
- `bin_valid` in 1 — one bin presented this cycle.
- `bin_data` in `WORD_W` — bin value.
- `bin_last` in 1 — qualifies the final bin of a frame.
- `chipselect` in 1 — bus select.
- `read` in 1 — read strobe.
- `write` in 1 — write strobe.
- `address` in `ADDR_W` — byte address.
- `writedata` in 8 — control byte.
- `readdata` out 8 — registered read byte.
- `frame_irq` out 1 — one-cycle pulse on publish.

## Operation
- Memory map (byte addresses, `B = NFFT*BYTES`):
  - `0..B-1`: bin `a/BYTES` of the read bank, byte `a%BYTES`, little-endian (byte 0 = bits [7:0]).
  - `B..B+3`: timestamp of the read bank, little-endian, zero-extended to 32 bits.
  - `B+4`: status byte `{4'b0, frame_err, lock, overrun, valid}`.
  - `B+5..B+7` and beyond: read 0x00.
- Control write (`chipselect && write`, any address ≥ `B`): `writedata[0]` sets `lock`; `writedata[1]=1` clears `overrun` and `frame_err`. Writes below `B` are ignored.
- Write side FSM:
  - `S_SYNC` (reset state): discard bins; `bin_valid && bin_last` → `S_FILL` with `widx=0`.
  - `S_FILL`: each `bin_valid` writes `bin_data` to the write bank at `widx`, then `widx++`.
  - `bin_last` at `widx==NFFT-1` → frame complete; stay in `S_FILL`, `widx=0`.
  - `bin_last` at `widx≠NFFT-1`, or `bin_valid` without `bin_last` at `widx==NFFT-1` → set `frame_err`, discard the frame, go to `S_SYNC` (the latter case waits for the next `bin_last`).
- Frame complete:
  - `frame_cnt` increments modulo `2**TIME_W`, whether or not the frame is published.
  - If `lock==0`: swap banks, latch the new `frame_cnt` as the read-bank timestamp, set `valid=1`, pulse `frame_irq`.
  - If `lock==1`: no swap, set `overrun`; the write bank is refilled by the next frame.
- A lock write and a frame complete in the same cycle: the new lock value applies, so lock=1 means the frame is not swapped.
- A clear and a new error in the same cycle: the set wins.

## Timing
- Reset values: `readdata=0`, `frame_irq=0`, `valid=0`, `overrun=0`, `frame_err=0`, `lock=0`, `frame_cnt=0`, timestamp 0, write bank 0, FSM `S_SYNC`. RAM contents are undefined; `valid=0` flags this.
- Read: `address` sampled at edge N with `chipselect && read`; `readdata` valid after edge N+1 and held until the next read.
- Bank swap at edge N: reads sampled at edge ≥ N+1 see the new bank.
- `frame_irq` is high for the cycle after the publishing edge.
- Ingest: 1 bin/cycle sustained with no backpressure; consecutive frames may be back-to-back.
- Reset mid-frame: the partial frame is lost and the FSM resyncs on the next `bin_last`.

## Structure
- `sfft_readout_pkg`:
  - status bit indices (`ST_VALID=0`, `ST_OVERRUN=1`, `ST_LOCK=2`, `ST_FERR=3`);
  - control bit indices (`CT_LOCK=0`, `CT_CLEAR=1`);
  - FSM state enum;
  - offsets `TS_OFS=0`, `STAT_OFS=4` relative to `B`.
- Sub-module `sfft_readout_ram`: simple dual-port, `2*NFFT × WORD_W`, bank bit as address MSB, 1-cycle registered read. Byte lane select uses `address%BYTES`, delayed one cycle.

## Test plan
- Reset, then read `B+4` → 0x00; feed 3 bins then `bin_last` on bin 3 with `NFFT=4` → first (partial) frame not published, `valid` stays 0.
- `NFFT=4`, `WORD_W=32`: sync frame, then bins 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00 → `frame_irq` one pulse; byte 0 = 0x44, byte 7 = 0x55; `B..B+3` = 01 00 00 00.
- Write lock=1, stream two more frames → no `frame_irq`, data unchanged, status = 0x07; write lock=0, then one frame → timestamp = 4.
- `bin_last` on bin 2 of 4 → status bit3 set, no publish; write 0x02 → status 0x01; next-but-one frame publishes.
- Lock write and frame complete on the same edge → no swap, `overrun=1`.
- `WORD_W=24`, `NFFT=8`: byte 3 maps to bin 1 byte 0; `B+5` reads 0x00.

Source files
------------

// File: rtl/sfft_readout_pkg.sv
// Shared constants for the SFFT frame readout: register bit positions,
// register-window offsets and the write-side FSM state type.
package sfft_readout_pkg;

  localparam int ST_VALID   = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_LOCK    = 2;
  localparam int ST_FERR    = 3;

  localparam int CT_LOCK  = 0;
  localparam int CT_CLEAR = 1;

  // Byte offsets of the register window that follows the bin area.
  localparam int TS_OFS   = 0;
  localparam int STAT_OFS = 4;

  typedef enum logic [0:0] {
    S_SYNC = 1'b0,
    S_FILL = 1'b1
  } wr_state_e;

endpackage

// File: rtl/sfft_readout_ram.sv
// Simple dual-port bin store. The bank bit is the address MSB. A read registers
// the whole word together with its byte lane, and the selected byte is muxed out.
module sfft_readout_ram #(
  parameter int DEPTH  = 1024,
  parameter int WORD_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  input  logic [2:0]        rd_lane,
  output logic [7:0]        rd_byte
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_word;
  logic [2:0]        lane_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) begin
      rd_word <= mem[rd_addr];
      lane_q  <= rd_lane;
    end
  end

  assign rd_byte = 8'(rd_word >> {lane_q, 3'b000});

endmodule

// File: rtl/sfft_frame_readout.sv
// Double-buffered SFFT frame capture with a byte-wide register/bin read port.
// Complete frames are published by a bank swap unless software holds the lock.
module sfft_frame_readout
  import sfft_readout_pkg::*;
#(
  parameter int NFFT   = 512,
  parameter int WORD_W = 32,
  parameter int TIME_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bin_valid,
  input  logic [WORD_W-1:0] bin_data,
  input  logic              bin_last,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic              frame_irq,
  output wr_state_e         fsm_state
);

  localparam int BYTES = WORD_W / 8;
  localparam int IW    = $clog2(NFFT);
  localparam logic [ADDR_W-1:0] B_ADDR = ADDR_W'(NFFT * BYTES);

  // Bin input: one bin per cycle when bin_valid is high; there is no ready,
  // the stage always accepts. Bus: a read or write is one cycle of chipselect
  // with the strobe; no wait states.

  wr_state_e         state, state_n;
  logic [IW-1:0]     widx, widx_n;
  logic              bank_w;
  logic              lock, valid, overrun, frame_err;
  logic [TIME_W-1:0] frame_cnt, ts;
  logic              frame_done, frame_bad, at_end;
  logic              ctl_wr, lock_n, clr, publish;

  assign at_end    = (widx == IW'(NFFT - 1));
  assign fsm_state = state;

  always_comb begin
    state_n    = state;
    widx_n     = widx;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      S_SYNC: begin
        if (bin_valid && bin_last) begin
          state_n = S_FILL;
          widx_n  = '0;
        end
      end
      S_FILL: begin
        if (bin_valid) begin
          if (bin_last && at_end) begin
            frame_done = 1'b1;
            widx_n     = '0;
          end else if (bin_last || at_end) begin
            frame_bad = 1'b1;
            state_n   = S_SYNC;
            widx_n    = '0;
          end else begin
            widx_n = widx + IW'(1);
          end
        end
      end
      default: state_n = S_SYNC;
    endcase
  end

  // A control write in the same cycle as a frame completion decides the swap.
  assign ctl_wr  = chipselect && write && (address >= B_ADDR);
  assign lock_n  = ctl_wr ? writedata[CT_LOCK] : lock;
  assign clr     = ctl_wr && writedata[CT_CLEAR];
  assign publish = frame_done && !lock_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_SYNC;
      widx      <= '0;
      bank_w    <= 1'b0;
      lock      <= 1'b0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      ts        <= '0;
      frame_irq <= 1'b0;
    end else begin
      state     <= state_n;
      widx      <= widx_n;
      lock      <= lock_n;
      frame_irq <= publish;
      overrun   <= (overrun && !clr) || (frame_done && lock_n);
      frame_err <= (frame_err && !clr) || frame_bad;
      if (frame_done) frame_cnt <= frame_cnt + TIME_W'(1);
      if (publish) begin
        bank_w <= ~bank_w;
        ts     <= frame_cnt + TIME_W'(1);
        valid  <= 1'b1;
      end
    end
  end

  // Read side: address decoded at the sampling edge, byte registered one edge later.
  logic [IW-1:0]     bin_idx;
  logic [2:0]        lane;
  logic [ADDR_W-1:0] ofs;
  logic [31:0]       ts32;
  logic [7:0]        stat, reg_byte, ram_byte, reg_q;
  logic              rd_req, is_ram, rd_q, is_ram_q;

  assign bin_idx = IW'(address / ADDR_W'(BYTES));
  assign lane    = 3'(address % ADDR_W'(BYTES));
  assign ofs     = address - B_ADDR;
  assign ts32    = 32'(ts);
  assign rd_req  = chipselect && read;
  assign is_ram  = (address < B_ADDR);

  always_comb begin
    stat              = '0;
    stat[ST_VALID]    = valid;
    stat[ST_OVERRUN]  = overrun;
    stat[ST_LOCK]     = lock;
    stat[ST_FERR]     = frame_err;
    reg_byte          = 8'h00;
    if (ofs < ADDR_W'(STAT_OFS)) reg_byte = 8'(ts32 >> {ofs[1:0], 3'b000});
    else if (ofs == ADDR_W'(STAT_OFS)) reg_byte = stat;
  end

  sfft_readout_ram #(
    .DEPTH  (2 * NFFT),
    .WORD_W (WORD_W),
    .AW     (IW + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (state == S_FILL && bin_valid),
    .wr_addr ({bank_w, widx}),
    .wr_data (bin_data),
    .rd_en   (rd_req && is_ram),
    .rd_addr ({~bank_w, bin_idx}),
    .rd_lane (lane),
    .rd_byte (ram_byte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q     <= 1'b0;
      is_ram_q <= 1'b0;
      reg_q    <= 8'h00;
      readdata <= 8'h00;
    end else begin
      rd_q <= rd_req;
      if (rd_req) begin
        is_ram_q <= is_ram;
        reg_q    <= reg_byte;
      end
      if (rd_q) readdata <= is_ram_q ? ram_byte : reg_q;
    end
  end

  logic unused_wd;
  assign unused_wd = ^writedata[7:2];

endmodule

// File: tb/tb_sfft_frame_readout.sv
// Directed bench for sfft_frame_readout: a 4x32 instance for frame/lock/error
// behaviour and an 8x24 instance for non-power-of-2 byte mapping.
module tb_sfft_frame_readout;
  import sfft_readout_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: NFFT=4, WORD_W=32, bin area 0..15, registers at 16..20
  logic        a_valid = 0, a_last = 0, a_cs = 0, a_rd = 0, a_wr = 0;
  logic [31:0] a_data = '0;
  logic [15:0] a_addr = '0;
  logic [7:0]  a_wd = '0, a_rdata;
  logic        a_irq;
  wr_state_e   a_state;

  // Instance B: NFFT=8, WORD_W=24, bin area 0..23, registers at 24..28
  logic        b_valid = 0, b_last = 0, b_cs = 0, b_rd = 0;
  logic [23:0] b_data = '0;
  logic [15:0] b_addr = '0;
  logic [7:0]  b_rdata;
  logic        b_irq;
  wr_state_e   b_state;

  sfft_frame_readout #(.NFFT(4), .WORD_W(32), .TIME_W(32), .ADDR_W(16)) dut_a (
    .clk(clk), .reset(reset), .bin_valid(a_valid), .bin_data(a_data), .bin_last(a_last),
    .chipselect(a_cs), .read(a_rd), .write(a_wr), .address(a_addr), .writedata(a_wd),
    .readdata(a_rdata), .frame_irq(a_irq), .fsm_state(a_state)
  );

  sfft_frame_readout #(.NFFT(8), .WORD_W(24), .TIME_W(16), .ADDR_W(16)) dut_b (
    .clk(clk), .reset(reset), .bin_valid(b_valid), .bin_data(b_data), .bin_last(b_last),
    .chipselect(b_cs), .read(b_rd), .write(1'b0), .address(b_addr), .writedata(8'h00),
    .readdata(b_rdata), .frame_irq(b_irq), .fsm_state(b_state)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each entry is {address, expected byte}
  logic [23:0] exp_a[$];
  logic [23:0] exp_b[$];
  logic a_p1 = 0, a_p2 = 0, b_p1 = 0, b_p2 = 0;
  int a_irq_cnt = 0, b_irq_cnt = 0;

  always @(posedge clk) begin
    a_p1 <= a_cs && a_rd;
    a_p2 <= a_p1;
    b_p1 <= b_cs && b_rd;
    b_p2 <= b_p1;
  end

  always @(negedge clk) begin
    if (a_irq === 1'b1) a_irq_cnt++;
    if (b_irq === 1'b1) b_irq_cnt++;
    if (a_p2) begin
      if (exp_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_a: readdata 0x%0h with nothing expected", a_rdata);
      end else begin
        logic [23:0] e;
        e = exp_a.pop_front();
        check($sformatf("rd_a[%0d]", e[23:8]), int'(a_rdata), int'(e[7:0]));
      end
    end
    if (b_p2) begin
      if (exp_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_b: readdata 0x%0h with nothing expected", b_rdata);
      end else begin
        logic [23:0] e;
        e = exp_b.pop_front();
        check($sformatf("rd_b[%0d]", e[23:8]), int'(b_rdata), int'(e[7:0]));
      end
    end
  end

  task automatic a_bin(input logic [31:0] d, input logic last);
    @(negedge clk); a_valid = 1'b1; a_data = d; a_last = last;
  endtask

  task automatic a_idle(input int n);
    @(negedge clk); a_valid = 1'b0; a_last = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic a_frame(input logic [31:0] w0, w1, w2, w3);
    a_bin(w0, 1'b0); a_bin(w1, 1'b0); a_bin(w2, 1'b0); a_bin(w3, 1'b1);
    a_idle(2);
  endtask

  task automatic a_read(input logic [15:0] addr, input logic [7:0] exp);
    @(negedge clk); a_cs = 1'b1; a_rd = 1'b1; a_addr = addr;
    exp_a.push_back({addr, exp});
    @(negedge clk); a_cs = 1'b0; a_rd = 1'b0;
  endtask

  task automatic a_write(input logic [15:0] addr, input logic [7:0] wd);
    @(negedge clk); a_cs = 1'b1; a_wr = 1'b1; a_addr = addr; a_wd = wd;
    @(negedge clk); a_cs = 1'b0; a_wr = 1'b0;
  endtask

  task automatic b_frame();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_valid = 1'b1; b_last = (i == 7);
      b_data  = {8'(8'hA0 + i), 8'(8'hB0 + i), 8'(8'hC0 + i)};
    end
    @(negedge clk); b_valid = 1'b0; b_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic b_read(input logic [15:0] addr, input logic [7:0] exp);
    @(negedge clk); b_cs = 1'b1; b_rd = 1'b1; b_addr = addr;
    exp_b.push_back({addr, exp});
    @(negedge clk); b_cs = 1'b0; b_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("reset_readdata", int'(a_rdata), 0);
    check("reset_irq", int'(a_irq), 0);
    check("reset_state", int'(a_state), int'(S_SYNC));

    a_read(16'd20, 8'h00);
    // Sync frame: discarded, only brings the FSM into FILL
    a_frame(32'h1, 32'h2, 32'h3, 32'h4);
    check("sync_irq", a_irq_cnt, 0);
    check("sync_state", int'(a_state), int'(S_FILL));
    a_read(16'd20, 8'h00);

    a_frame(32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00);
    check("f1_irq", a_irq_cnt, 1);
    a_read(16'd0, 8'h44);  a_read(16'd1, 8'h33);  a_read(16'd7, 8'h55);
    a_read(16'd15, 8'hDD); a_read(16'd16, 8'h01); a_read(16'd17, 8'h00);
    a_read(16'd18, 8'h00); a_read(16'd19, 8'h00); a_read(16'd20, 8'h01);
    a_read(16'd21, 8'h00);

    // Locked: frames complete and count, but stay in the write bank
    a_write(16'd20, 8'h01);
    a_read(16'd20, 8'h05);
    a_frame(32'hA1A2A3A4, 32'hA5A6A7A8, 32'hA9AAABAC, 32'hADAEAFB0);
    a_frame(32'hB1B2B3B4, 32'hB5B6B7B8, 32'hB9BABBBC, 32'hBDBEBFC0);
    check("lock_irq", a_irq_cnt, 1);
    a_read(16'd0, 8'h44); a_read(16'd20, 8'h07); a_read(16'd16, 8'h01);

    a_write(16'd16, 8'h00);
    a_frame(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
    check("unlock_irq", a_irq_cnt, 2);
    a_read(16'd16, 8'h04); a_read(16'd0, 8'h04); a_read(16'd12, 8'h10);
    a_read(16'd20, 8'h03);
    a_write(16'd20, 8'h02);
    a_read(16'd20, 8'h01);

    // Early bin_last: framing error, resync
    a_bin(32'hC1, 1'b0); a_bin(32'hC2, 1'b0); a_bin(32'hC3, 1'b1); a_idle(2);
    check("ferr_state", int'(a_state), int'(S_SYNC));
    a_read(16'd20, 8'h09);
    a_write(16'd20, 8'h02);
    a_read(16'd20, 8'h01);
    a_frame(32'hE1, 32'hE2, 32'hE3, 32'hE4);
    check("ferr_sync_irq", a_irq_cnt, 2);
    a_frame(32'h000000F6, 32'h0, 32'h0, 32'h0);
    check("ferr_pub_irq", a_irq_cnt, 3);
    a_read(16'd16, 8'h05); a_read(16'd0, 8'hF6);

    // Missing bin_last on the final bin: error, then resync on the next bin_last
    a_bin(32'h1, 1'b0); a_bin(32'h2, 1'b0); a_bin(32'h3, 1'b0); a_bin(32'h4, 1'b0);
    a_bin(32'h5, 1'b1); a_idle(2);
    a_read(16'd20, 8'h09);
    a_write(16'd20, 8'h02);
    a_frame(32'h77665544, 32'h0, 32'h0, 32'h0);
    check("nolast_irq", a_irq_cnt, 4);
    a_read(16'd16, 8'h06); a_read(16'd0, 8'h44); a_read(16'd20, 8'h01);

    // Lock write lands on the same edge as the frame completion
    a_bin(32'h88000001, 1'b0); a_bin(32'h88000002, 1'b0); a_bin(32'h88000003, 1'b0);
    @(negedge clk);
    a_valid = 1'b1; a_data = 32'h88000004; a_last = 1'b1;
    a_cs = 1'b1; a_wr = 1'b1; a_addr = 16'd20; a_wd = 8'h01;
    @(negedge clk);
    a_valid = 1'b0; a_last = 1'b0; a_cs = 1'b0; a_wr = 1'b0;
    a_idle(2);
    check("race_irq", a_irq_cnt, 4);
    a_read(16'd20, 8'h07); a_read(16'd0, 8'h44); a_read(16'd16, 8'h06);

    // 24-bit bins: three bytes per bin
    b_frame();
    check("b_sync_irq", b_irq_cnt, 0);
    b_frame();
    check("b_irq", b_irq_cnt, 1);
    b_read(16'd0, 8'hC0);  b_read(16'd2, 8'hA0);  b_read(16'd3, 8'hC1);
    b_read(16'd5, 8'hA1);  b_read(16'd23, 8'hA7); b_read(16'd24, 8'h01);
    b_read(16'd28, 8'h01); b_read(16'd29, 8'h00); b_read(16'd31, 8'h00);

    repeat (4) @(negedge clk);
    check("drain_a", exp_a.size(), 0);
    check("drain_b", exp_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
